// File: rtl/elevador_pkg.sv
// Shared elevator definitions: cabin FSM state encoding and the floor codes
// that the controller's display decoder also uses.
package elevador_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2,
    FALLA    = 2'd3
  } estado_t;

  localparam logic [3:0] PISO1 = 4'b0001;
  localparam logic [3:0] PISO2 = 4'b0010;
  localparam logic [3:0] PISO3 = 4'b0011;

endpackage

// File: rtl/cabina_temporizador.sv
// Travel timer for one floor: counts enabled cycles, saturates at
// TRAVEL_CYCLES-1 and flags that value on tc.
module cabina_temporizador #(
  parameter int unsigned TRAVEL_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CNT_W = $clog2(TRAVEL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TRAVEL_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_MAX);

endmodule

// File: rtl/elevador_cabina.sv
// Cabin position model driven by the floor controller's motor commands.
// Define CABINA_LIMIT_FAULT_EN to turn a command past the end floors into a fault.
module elevador_cabina
  import elevador_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned NUM_PISOS     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       motorsubir,
  input  logic       motorbajar,
  output logic [3:0] dato,
  output logic       en_movimiento,
  output logic       llegada,
  output logic       falla
);

  localparam int unsigned PISO_W = (NUM_PISOS > 1) ? $clog2(NUM_PISOS) : 1;
  localparam logic [PISO_W-1:0] PISO_TOP = PISO_W'(NUM_PISOS - 1);

  estado_t           state, state_n;
  logic [PISO_W-1:0] piso, piso_n;
  logic              clr, en, tc, llegada_n, conflicto;

  cabina_temporizador #(
    .TRAVEL_CYCLES(TRAVEL_CYCLES)
  ) u_temporizador (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (en),
    .tc   (tc)
  );

  assign conflicto = motorsubir && motorbajar;

  always_comb begin
    state_n   = state;
    piso_n    = piso;
    clr       = 1'b0;
    en        = 1'b0;
    llegada_n = 1'b0;
    unique case (state)
      PARADO: begin
        if (conflicto) begin
          state_n = FALLA;
        end else if (motorsubir) begin
          if (piso == PISO_TOP) begin
`ifdef CABINA_LIMIT_FAULT_EN
            state_n = FALLA;
`else
            state_n = PARADO;
`endif
          end else begin
            state_n = SUBIENDO;
            clr     = 1'b1;
          end
        end else if (motorbajar) begin
          if (piso == '0) begin
`ifdef CABINA_LIMIT_FAULT_EN
            state_n = FALLA;
`else
            state_n = PARADO;
`endif
          end else begin
            state_n = BAJANDO;
            clr     = 1'b1;
          end
        end
      end
      SUBIENDO, BAJANDO: begin
        if (conflicto) begin
          state_n = FALLA;
        end else if ((state == SUBIENDO) ? motorsubir : motorbajar) begin
          if (tc) begin
            piso_n    = (state == SUBIENDO) ? piso + PISO_W'(1) : piso - PISO_W'(1);
            llegada_n = 1'b1;
            clr       = 1'b1;
            state_n   = PARADO;
          end else begin
            en = 1'b1;
          end
        end else begin
          // Command dropped mid-travel: partial progress is discarded.
          clr     = 1'b1;
          state_n = PARADO;
        end
      end
      FALLA: state_n = FALLA;
      default: state_n = FALLA;
    endcase
  end

  // Outputs follow the next-state values so dato and llegada change on the arrival edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= PARADO;
      piso          <= '0;
      dato          <= PISO1;
      en_movimiento <= 1'b0;
      llegada       <= 1'b0;
      falla         <= 1'b0;
    end else begin
      state         <= state_n;
      piso          <= piso_n;
      dato          <= 4'(piso_n) + 4'd1;
      en_movimiento <= (state_n == SUBIENDO) || (state_n == BAJANDO);
      llegada       <= llegada_n;
      falla         <= (state_n == FALLA);
    end
  end

endmodule

// File: doc/elevador_cabina.md
# elevador_cabina

Cabin position model for the elevator: the motor-side counterpart of the floor controller. It consumes the controller's `motorsubir`/`motorbajar` commands, times travel between floors, and produces the 4-bit floor code `dato` that the controller feeds back to its 7-segment decoder. It also provides arrival, in-motion and fault indications.

## Interface
- `TRAVEL_CYCLES`, default 8: clock cycles of continuous motor command needed to move one floor; must be ≥ 2.
- `NUM_PISOS`, default 3: number of floors; the floor index runs 0..NUM_PISOS-1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `motorsubir` in 1: up command from the floor controller.
- `motorbajar` in 1: down command from the floor controller.
- `dato` out 4: current floor code, floor index + 1 (4'b0001..4'b0011 for 3 floors).
- `en_movimiento` out 1: high while in SUBIENDO or BAJANDO.
- `llegada` out 1: one-cycle pulse on reaching a new floor.
- `falla` out 1: sticky fault flag.

## Operation
- The FSM has four states: PARADO, SUBIENDO, BAJANDO, FALLA.
- Internal `piso` register is $clog2(NUM_PISOS) bits wide. `cnt` is $clog2(TRAVEL_CYCLES) bits wide and saturates at TRAVEL_CYCLES-1.
- `dato` = {zero-extend, piso} + 1, registered from `piso`.
- Reset values:
  - state PARADO, `piso`=0, `cnt`=0.
  - `dato`=4'b0001, `en_movimiento`=0, `llegada`=0, `falla`=0.
- `motorsubir` and `motorbajar` both high in any state except FALLA → FALLA. This check has priority over every other transition.
- PARADO:
  - `motorsubir` → SUBIENDO, `cnt`=0.
  - `motorbajar` → BAJANDO, `cnt`=0.
  - Neither → stay.
- SUBIENDO with `motorsubir` still high:
  - If `cnt`==TRAVEL_CYCLES-1: `piso`+1, `llegada`=1 for one cycle, `cnt`=0, → PARADO.
  - Otherwise `cnt`+1.
- BAJANDO behaves the same with `motorbajar`, and `piso` decrements.
- Motor command dropped mid-travel → PARADO, `cnt`=0, `piso` unchanged, no `llegada`. Partial travel is discarded.
- Continuous command across floors passes through one PARADO cycle between floors.
- Limit command: `motorsubir` at `piso`==NUM_PISOS-1, or `motorbajar` at `piso`==0. Behaviour is set by the macro (see Configuration).
- FALLA:
  - `falla`=1, `en_movimiento`=0, `llegada`=0, `dato` holds.
  - Exited only by reset.

## Timing
- All outputs are registered; nothing is combinational from the inputs.
- Latency: motor command first sampled high at edge k (in PARADO) → `dato` updates and `llegada` pulses after edge k+TRAVEL_CYCLES.
- Consecutive floors under a held command: arrivals at k+T, k+2T+1, and so on.
- Fault: the both-high condition sampled at edge k → `falla` high after edge k.
- Reset: `rst_n` low sampled at any edge, including mid-travel or in FALLA → all reset values after that edge.

## Configuration
- `CABINA_LIMIT_FAULT_EN` defined: a limit command in PARADO → FALLA (overtravel fault).
- Undefined: a limit command is ignored. The FSM stays in PARADO, `en_movimiento`=0, `piso` is saturated.
- The both-high fault is always present, independent of the macro.

## Structure
- Shared package `elevador_pkg` holds:
  - the state encoding (PARADO/SUBIENDO/BAJANDO/FALLA, 2 bits);
  - the floor-code constants (PISO1=4'b0001, PISO2=4'b0010, PISO3=4'b0011), reused by the controller's display decoder.
- One sub-module, `cabina_temporizador`: the travel counter with clear, enable and a terminal-count output.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with random motor inputs → `dato`=4'b0001, `en_movimiento`=`llegada`=`falla`=0.
- Single floor, TRAVEL_CYCLES=4: `motorsubir`=1 from edge 0 → `en_movimiento` high after edge 0; `llegada` pulse and `dato`=4'b0010 after edge 4.
  - Keep the command held → `dato`=4'b0011 with `llegada` after edge 9.
- Abort: `motorsubir` high at edges 0–2, low at edge 3 → PARADO after edge 3, `dato` unchanged, no `llegada`.
- Conflict: both motors high at edge 5 → `falla`=1 after edge 5. Drop both inputs → `falla` stays 1 until `rst_n`=0.
- Limit: at `dato`=4'b0011, assert `motorsubir`:
  - macro defined → `falla`=1 next edge;
  - undefined → `en_movimiento`=0, `dato`=4'b0011 indefinitely.
- Reset mid-travel: `rst_n`=0 during BAJANDO with `cnt`=2 → after that edge `dato`=4'b0001, `en_movimiento`=0, no `llegada`.
